// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered N-to-1 multiplexer of WIDTH-bit channels.
// Manual mode picks the channel from sel (out-of-range requests are ignored).
// Scan mode rotates through every channel, dwelling DWELL cycles on each;
// hold freezes the rotation while out keeps tracking live channel data.
// out, channel and tick are all registered from the same next-channel value,
// so they always agree with each other in any given cycle.
module mux_nx1_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          channel,
  output logic                      tick
);

  // A DWELL of 1 still needs a one-bit counter that simply stays at zero.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  // One extra bit so CHANNELS == 2**SEL_W is representable for the range check.
  localparam logic [SEL_W:0]   NUM_CH   = (SEL_W + 1)'(CHANNELS);

  logic [SEL_W-1:0] ch;
  logic [SEL_W-1:0] ch_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] data_n;

  // Next channel and dwell count from the current mode, hold and counter state.
  always_comb begin
    ch_n  = ch;
    cnt_n = cnt;
    if (!mode) begin
      cnt_n = '0;
      if ({1'b0, sel} < NUM_CH) begin
        ch_n = sel;
      end
    end else if (!hold) begin
      if (cnt == LAST_CNT) begin
        cnt_n = '0;
        ch_n  = (ch == LAST_CH) ? '0 : ch + 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  // Pick the slice for the next channel so out lines up with channel.
  always_comb begin
    data_n = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_n == SEL_W'(k)) begin
        data_n = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // State and output registers; reset wins over everything, including scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch   <= '0;
      cnt  <= '0;
      out  <= '0;
      tick <= 1'b0;
    end else begin
      ch   <= ch_n;
      cnt  <= cnt_n;
      out  <= data_n;
      tick <= (ch_n != ch);
    end
  end

  assign channel = ch;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: directed vectors for a 4-channel and a 3-channel instance.
// Each vector pushes its hand-computed response into a per-instance queue;
// a monitor per instance pops and compares one entry after every clock edge.
module tb_mux_nx1_scan;

  typedef struct {
    logic [3:0] out;
    logic [1:0] ch;
    logic       tick;
    int         step;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        reset4 = 1'b1;
  logic [15:0] data4  = 16'hDCBA;
  logic [1:0]  sel4   = 2'd0;
  logic        mode4  = 1'b0;
  logic        hold4  = 1'b0;
  logic [3:0]  out4;
  logic [1:0]  ch4;
  logic        tick4;

  // 3-channel instance
  logic        reset3 = 1'b1;
  logic [11:0] data3  = 12'h321;
  logic [1:0]  sel3   = 2'd0;
  logic        mode3  = 1'b0;
  logic        hold3  = 1'b0;
  logic [3:0]  out3;
  logic [1:0]  ch3;
  logic        tick3;

  exp_t q4[$];
  exp_t q3[$];
  int   checks   = 0;
  int   failures = 0;
  int   stepNum  = 0;

  mux_nx1_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut4 (
    .clk(clk), .reset(reset4), .data_in(data4), .sel(sel4), .mode(mode4),
    .hold(hold4), .out(out4), .channel(ch4), .tick(tick4)
  );

  mux_nx1_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(4)) dut3 (
    .clk(clk), .reset(reset3), .data_in(data3), .sel(sel3), .mode(mode3),
    .hold(hold3), .out(out3), .channel(ch3), .tick(tick3)
  );

  // Compare one registered response against its expected entry.
  task automatic checkOutput(input string tag, input exp_t e,
                             input logic [3:0] aOut, input logic [1:0] aCh,
                             input logic aTick);
    checks++;
    if (aOut !== e.out || aCh !== e.ch || aTick !== e.tick) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got out=%h channel=%0d tick=%b, expected out=%h channel=%0d tick=%b",
               tag, e.step, aOut, aCh, aTick, e.out, e.ch, e.tick);
    end
  endtask

  // Drive one cycle of inputs away from the edge and queue the response
  // expected right after the following rising edge.
  task automatic applyStimulus(input bit useDut3, input logic rst,
                               input logic [1:0] s, input logic m,
                               input logic h, input logic [15:0] d,
                               input logic [3:0] eOut, input logic [1:0] eCh,
                               input logic eTick);
    exp_t e;
    @(negedge clk);
    stepNum++;
    e.out  = eOut;
    e.ch   = eCh;
    e.tick = eTick;
    e.step = stepNum;
    if (useDut3) begin
      reset3 = rst; sel3 = s; mode3 = m; hold3 = h; data3 = d[11:0];
      q3.push_back(e);
    end else begin
      reset4 = rst; sel4 = s; mode4 = m; hold4 = h; data4 = d;
      q4.push_back(e);
    end
  endtask

  // Monitors: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checkOutput("dut4", e, out4, ch4, tick4);
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q3.size() > 0) begin
      e = q3.pop_front();
      checkOutput("dut3", e, out3, ch3, tick3);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  vals [4];
    logic [15:0] d;
    vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
    d = 16'hDCBA;

    // Reset held for two edges with arbitrary sel/mode, then release.
    applyStimulus(0, 1, 2'd2, 1, 0, d, 4'h0, 2'd0, 0);
    applyStimulus(0, 1, 2'd3, 1, 0, d, 4'h0, 2'd0, 0);
    applyStimulus(0, 0, 2'd0, 0, 0, d, 4'hA, 2'd0, 0);

    // Manual selection, each request held two cycles.
    for (int s = 1; s <= 4; s++) begin
      applyStimulus(0, 0, 2'(s % 4), 0, 0, d, vals[s % 4], 2'(s % 4), 1);
      applyStimulus(0, 0, 2'(s % 4), 0, 0, d, vals[s % 4], 2'(s % 4), 0);
    end

    // Scan from channel 0 through the 3->0 wrap.
    for (int c = 0; c < 4; c++) begin
      repeat (3) applyStimulus(0, 0, 2'd0, 1, 0, d, vals[c], 2'(c), 0);
      applyStimulus(0, 0, 2'd0, 1, 0, d, vals[(c + 1) % 4], 2'((c + 1) % 4), 1);
    end

    // Advance to channel 1 and dwell two cycles there.
    repeat (3) applyStimulus(0, 0, 2'd0, 1, 0, d, 4'hA, 2'd0, 0);
    applyStimulus(0, 0, 2'd0, 1, 0, d, 4'hB, 2'd1, 1);
    repeat (2) applyStimulus(0, 0, 2'd0, 1, 0, d, 4'hB, 2'd1, 0);

    // Hold for six cycles while channel 1 data changes to 7.
    d = 16'hDC7A;
    repeat (6) applyStimulus(0, 0, 2'd0, 1, 1, d, 4'h7, 2'd1, 0);
    applyStimulus(0, 0, 2'd0, 1, 0, d, 4'h7, 2'd1, 0);
    applyStimulus(0, 0, 2'd0, 1, 0, d, 4'hC, 2'd2, 1);

    // Reset mid-scan at channel 2 with two dwell cycles counted.
    repeat (2) applyStimulus(0, 0, 2'd0, 1, 0, d, 4'hC, 2'd2, 0);
    applyStimulus(0, 1, 2'd0, 1, 0, d, 4'h0, 2'd0, 0);
    repeat (3) applyStimulus(0, 0, 2'd0, 1, 0, d, 4'hA, 2'd0, 0);
    applyStimulus(0, 0, 2'd0, 1, 0, d, 4'h7, 2'd1, 1);

    // Three-channel instance: reset, manual, out-of-range request, scan wrap.
    d = 16'h0321;
    applyStimulus(1, 1, 2'd0, 0, 0, d, 4'h0, 2'd0, 0);
    applyStimulus(1, 0, 2'd1, 0, 0, d, 4'h2, 2'd1, 1);
    repeat (2) applyStimulus(1, 0, 2'd3, 0, 0, d, 4'h2, 2'd1, 0);
    repeat (3) applyStimulus(1, 0, 2'd3, 1, 0, d, 4'h2, 2'd1, 0);
    applyStimulus(1, 0, 2'd3, 1, 0, d, 4'h3, 2'd2, 1);
    repeat (3) applyStimulus(1, 0, 2'd3, 1, 0, d, 4'h3, 2'd2, 0);
    applyStimulus(1, 0, 2'd3, 1, 0, d, 4'h1, 2'd0, 1);
    repeat (3) applyStimulus(1, 0, 2'd3, 1, 0, d, 4'h1, 2'd0, 0);
    applyStimulus(1, 0, 2'd3, 1, 0, d, 4'h2, 2'd1, 1);

    // Let the monitors drain, then confirm nothing was left unchecked.
    repeat (3) @(negedge clk);
    checks++;
    if (q4.size() != 0 || q3.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got pending=%0d, expected pending=0",
               q4.size() + q3.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
Parametrised, registered N-to-1 multiplexer of WIDTH-bit channels, the next generation of the team's single-bit 2-to-1 mux.
- Manual mode: a select input picks the channel.
- Scan mode: an internal dwell counter rotates through all channels, for time-multiplexed display and bus sharing.
- Outputs: the selected data, the active channel index, and a one-cycle tick on every channel change.

Parameters:
WIDTH, 4, bit width of each channel
CHANNELS, 4, number of input channels (2..2**SEL_W; need not be a power of two)
SEL_W, 2, width of sel/channel index; must satisfy 2**SEL_W >= CHANNELS
DWELL, 4, clock cycles spent on each channel in scan mode (>= 1)

Ports:
clk      input   1               single system clock, rising edge
reset    input   1               synchronous, active-high reset
data_in  input   CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH]
sel      input   SEL_W           channel request, used in manual mode
mode     input   1               0 = manual, 1 = scan
hold     input   1               scan mode only: freeze rotation
out      output  WIDTH           registered selected channel data
channel  output  SEL_W           registered active channel index
tick     output  1               registered pulse, 1 cycle per channel change

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: has priority over all other inputs, including mid-scan. On the edge: out=0, channel=0, tick=0, dwell counter=0.
- State: channel register (ch), dwell counter cnt (0..DWELL-1), out, tick. All update on the rising edge only.
- Next channel ch_n, computed each cycle:
  - Manual (mode=0): ch_n = sel if sel < CHANNELS, otherwise ch_n = ch (out-of-range request ignored). cnt <= 0.
  - Scan, hold=1: ch_n = ch; cnt holds.
  - Scan, hold=0, cnt < DWELL-1: cnt <= cnt+1; ch_n = ch.
  - Scan, hold=0, cnt == DWELL-1: cnt <= 0; ch_n = (ch == CHANNELS-1) ? 0 : ch+1.
  - DWELL=1: channel advances every cycle while hold=0.
- Register updates each edge:
  - ch <= ch_n.
  - out <= data_in slice ch_n, so out and channel are always consistent in the same cycle.
  - tick <= (ch_n != ch).
- Latency: a data_in change on the active channel appears on out after 1 edge. A sel change in manual mode appears on channel and out after 1 edge.
- Data tracking: out follows live data_in of the active channel every cycle, including during hold.
- Mode changes:
  - Manual->scan: rotation starts from the current ch with cnt=0; the first advance occurs DWELL edges later.
  - Scan->manual: cnt cleared; ch <= sel (if in range) on the first manual edge.
- Wrap-around: always CHANNELS-1 -> 0; indices >= CHANNELS are never produced.
- First edge after reset release: out = channel 0 data; tick=0 unless ch_n != 0.

Test Plan:
All directed scenarios use WIDTH=4, CHANNELS=4, DWELL=4 and data_in = {4'hD,4'hC,4'hB,4'hA} (channel 0 = 4'hA), except scenario 5.

1. Reset: hold reset=1 for 2 edges with arbitrary sel/mode -> out=0, channel=0, tick=0. After release in manual mode with sel=0, the next edge gives out=4'hA, tick=0.
2. Manual select: mode=0; sel=1,2,3,0, each held 2 cycles -> out = B,C,D,A one edge after each change. tick=1 for exactly the first cycle of each change; a repeated sel gives tick=0.
3. Scan: mode=1 from channel 0, hold=0 -> channel sequence 0,1,2,3,0, each held 4 cycles, out = A,B,C,D,A. tick=1 for one cycle at each advance, including the 3->0 wrap.
4. Hold: in scan on channel 1 after 2 dwell cycles, hold=1 for 6 cycles and change channel 1 data to 4'h7 -> channel stays 1, tick=0, out=4'h7 one edge later. After hold=0, the advance to channel 2 occurs 2 edges later.
5. Non-power-of-two: CHANNELS=3, SEL_W=2, data_in = {4'h3,4'h2,4'h1}.
   - Manual: sel=3 from channel 1 -> channel stays 1, tick=0.
   - Scan: channel sequence 1,2,0 with out = 2,3,1.
6. Reset mid-operation: assert reset in scan at channel 2, cnt=2 -> next edge out=0, channel=0, tick=0. After release with mode=1, channel 0 is held a full 4 cycles before advancing to 1.
